// File: rtl/alu_src_stage.sv
// rtl/alu_src_stage.sv - ALU operand source select with a two-entry skid buffer
// Optional constant source: define ALU_SRC_STAGE_CONST_EN to make sel == NUM_SRC pick CONST_VAL.
module alu_src_stage #(
   parameter int               WIDTH     = 32,
   parameter int               NUM_SRC   = 4,
   parameter int               SEL_W     = 2,
   parameter logic [WIDTH-1:0] CONST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     sel_err
);

`ifdef ALU_SRC_STAGE_CONST_EN
   localparam bit CONST_EN = 1'b1;
`else
   localparam bit CONST_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   main_data_q, main_data_d;
   logic [WIDTH-1:0]   skid_data_q, skid_data_d;
   logic [SEL_W-1:0]   main_sel_q, main_sel_d;
   logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               sel_err_q, sel_err_d;

   logic [WIDTH-1:0]   pick_data;
   logic               pick_bad;
   logic               in_xfer;
   logic               out_xfer;

   // in_ready and out_valid are registers so neither handshake output depends
   // combinationally on the other side of the stage.
   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   // Resolve the offered selector into an operand; unknown sources read as zero
   always_comb begin
      pick_data = '0;
      pick_bad  = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (int'(sel) == i) begin
            pick_data = src_data[i*WIDTH +: WIDTH];
            pick_bad  = 1'b0;
         end
      end
      if (CONST_EN && (int'(sel) == NUM_SRC)) begin
         pick_data = CONST_VAL;
         pick_bad  = 1'b0;
      end
   end

   // Occupancy FSM: main register feeds the outputs, skid absorbs one stalled operand
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_sel_d  = main_sel_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      sel_err_d   = sel_err_q | (in_xfer & pick_bad);
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d     = ONE;
               main_data_d = pick_data;
               main_sel_d  = sel;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_data_d = pick_data;
               main_sel_d  = sel;
            end else if (in_xfer) begin
               state_d     = TWO;
               skid_data_d = pick_data;
               skid_sel_d  = sel;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_d     = ONE;
               main_data_d = skid_data_q;
               main_sel_d  = skid_sel_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   // State and data registers; reset wins over flush and any transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_sel_q  <= '0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_sel_q  <= main_sel_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data_q;
   assign out_sel   = main_sel_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_alu_src_stage.sv
// tb/tb_alu_src_stage.sv - self-checking bench for alu_src_stage
module tb_alu_src_stage;
   localparam int               WIDTH     = 32;
   localparam int               NUM_SRC   = 2;
   localparam int               SEL_W     = 2;
   localparam logic [WIDTH-1:0] CONST_VAL = 32'd4;

   logic                     clk = 1'b0;
   logic                     reset, flush, in_valid, in_ready, out_valid, out_ready, sel_err;
   logic [SEL_W-1:0]         sel, out_sel;
   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [WIDTH-1:0]         out_data;

   always #5 clk = ~clk;

   alu_src_stage #(
      .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CONST_VAL(CONST_VAL)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .src_data(src_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sel(out_sel), .sel_err(sel_err)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
   } op_t;

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] exp_data;
      logic             exp_err;
   } vec_t;

   op_t  mq[$];
   bit   m_err;
   int   checks = 0;
   int   errors = 0;
   vec_t vt[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference operand: selected source, optional constant, else zero with error
   function automatic op_t ref_op(input logic [SEL_W-1:0] s,
                                  input logic [NUM_SRC*WIDTH-1:0] src,
                                  output bit bad);
      op_t o;
      int  idx;
      idx   = int'(s);
      o.sel = s;
      bad   = 1'b0;
      if (idx < NUM_SRC) o.data = src[idx*WIDTH +: WIDTH];
`ifdef ALU_SRC_STAGE_CONST_EN
      else if (idx == NUM_SRC) o.data = CONST_VAL;
`endif
      else begin
         o.data = '0;
         bad    = 1'b1;
      end
      return o;
   endfunction

   task automatic check_model();
      @(negedge clk);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("sel_err", sel_err, m_err);
      if (mq.size() != 0) begin
         chk("out_data", out_data, mq[0].data);
         chk("out_sel", out_sel, mq[0].sel);
      end
   endtask

   task automatic tick();
      op_t o;
      bit  bad, ixf, oxf;
      @(posedge clk);
      ixf = in_valid && (mq.size() < 2);
      oxf = (mq.size() != 0) && out_ready;
      o   = ref_op(sel, src_data, bad);
      if (reset) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         if (ixf && bad) m_err = 1'b1;
         if (flush) mq.delete();
         else begin
            if (oxf) void'(mq.pop_front());
            if (ixf) mq.push_back(o);
         end
      end
      #1;
   endtask

   task automatic cycle();
      check_model();
      tick();
   endtask

   // Call with reset held high after at least one reset edge
   task automatic peek_reset(input string tag);
      @(negedge clk);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_sel"}, out_sel, 0);
      chk({tag, "_sel_err"}, sel_err, 0);
      tick();
   endtask

   task automatic push(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] a);
      in_valid = 1'b1;
      sel      = s;
      src_data = {a, pc};
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      int nvalid;
      vt[0] = '{2'd1, 32'h0000_0000, 32'h0000_1234, 32'h0000_1234, 1'b0};
      vt[1] = '{2'd0, 32'h0040_0000, 32'h1111_1111, 32'h0040_0000, 1'b0};
      vt[2] = '{2'd1, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      vt[3] = '{2'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0};
      vt[4] = '{2'd3, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
`ifdef ALU_SRC_STAGE_CONST_EN
      vt[5] = '{2'd2, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0004, 1'b0};
`else
      vt[5] = '{2'd2, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
`endif

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sel = '0; src_data = '0; m_err = 1'b0;
      tick();
      peek_reset("reset");
      reset = 1'b0;

      // Single-operand vectors, each from a fresh reset
      foreach (vt[k]) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         out_ready = 1'b1;
         push(vt[k].sel, vt[k].pc, vt[k].a);
         check_model();
         chk($sformatf("vec%0d_valid", k), out_valid, 1);
         chk($sformatf("vec%0d_data", k), out_data, vt[k].exp_data);
         chk($sformatf("vec%0d_sel", k), out_sel, vt[k].sel);
         chk($sformatf("vec%0d_err", k), sel_err, vt[k].exp_err);
         tick();
      end

      // Error flag stays set through later good operands until reset
      for (int i = 0; i < 3; i++) push(2'd0, 32'h10 + i, 32'h20);
      check_model();
      chk("sticky_err", sel_err, vt[5].exp_err);
      reset = 1'b1;
      tick();
      peek_reset("err_clear");
      reset = 1'b0;

      // Stall fills both entries, then drains back-to-back in order
      out_ready = 1'b0;
      push(2'd0, 32'h0040_0000, 32'h0);
      push(2'd1, 32'h0, 32'h0000_00FF);
      check_model();
      chk("stall_in_ready", in_ready, 0);
      tick();
      out_ready = 1'b1;
      check_model();
      chk("drain0_data", out_data, 32'h0040_0000);
      tick();
      check_model();
      chk("drain1_valid", out_valid, 1);
      chk("drain1_data", out_data, 32'h0000_00FF);
      tick();
      cycle();

      // Full throughput with alternating selectors
      nvalid = 0;
      for (int i = 0; i < 101; i++) begin
         in_valid = (i < 100);
         sel      = SEL_W'(i % 2);
         src_data = {$urandom, $urandom};
         check_model();
         if (out_valid) nvalid++;
         tick();
      end
      in_valid = 1'b0;
      chk("throughput_count", nvalid, 100);

      // Flush while full with a simultaneous offer discards everything
      out_ready = 1'b0;
      push(2'd0, 32'hCAFE_0000, 32'h0);
      push(2'd1, 32'h0, 32'hCAFE_0001);
      in_valid = 1'b1; flush = 1'b1; sel = 2'd0; src_data = {32'h0, 32'hBAD0_BAD0};
      cycle();
      in_valid = 1'b0; flush = 1'b0;
      check_model();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Reset while full and stalled
      out_ready = 1'b0;
      push(2'd1, 32'h0, 32'h7777_7777);
      push(2'd0, 32'h8888_8888, 32'h0);
      reset = 1'b1;
      cycle();
      peek_reset("reset_two");
      reset = 1'b0;

      // Random traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 3) != 0);
         sel       = flush ? SEL_W'($urandom_range(0, NUM_SRC - 1)) : SEL_W'($urandom_range(0, 3));
         src_data  = {$urandom, $urandom};
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_src_stage.md
ALU_SRC_STAGE -- requirements
Module: alu_src_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand data width in bits.
REQ-002 Parameter NUM_SRC, default 4, number of operand sources (2..16).
REQ-003 Parameter SEL_W, default 2, selector width; SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 Parameter CONST_VAL, default 0, WIDTH-bit constant source value.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous discard of all buffered operands.
REQ-008 in_valid  input  1  upstream offers sel/src_data this cycle.
REQ-009 in_ready  output  1  stage accepts when high; registered, no combinational path from out_ready.
REQ-010 sel  input  SEL_W  source index; index i picks src_data[i*WIDTH +: WIDTH].
REQ-011 src_data  input  NUM_SRC*WIDTH  packed operand sources, source 0 in LSBs (0 = PC, 1 = register A in default build).
REQ-012 out_valid  output  1  out_data/out_sel hold a valid operand.
REQ-013 out_ready  input  1  downstream (ALU) consumes when high with out_valid.
REQ-014 out_data  output  WIDTH  selected operand.
REQ-015 out_sel  output  SEL_W  selector that produced out_data.
REQ-016 sel_err  output  1  sticky flag: an out-of-range selector was accepted.

Function
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Operand SHALL be sampled at the input transfer edge; out_valid rises the next cycle (latency 1).
REQ-019 Storage: main register (drives outputs) plus one skid register; states EMPTY, ONE, TWO.
REQ-020 EMPTY: in -> ONE; no in -> EMPTY.
REQ-021 ONE: in only -> TWO if out stalled; in and out -> ONE (main reloaded); out only -> EMPTY; neither -> ONE.
REQ-022 TWO: out -> ONE (skid moves to main); no out -> TWO; in_ready low in TWO.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; zero bubbles at full throughput.
REQ-024 Order SHALL be preserved; no operand duplicated or dropped except by flush/reset.
REQ-025 out_data/out_sel SHALL be stable while out_valid && !out_ready.
REQ-026 sel >= NUM_SRC (no const source): stored operand SHALL be 0 and sel_err set on that input transfer.
REQ-027 flush SHALL force EMPTY next cycle, overriding simultaneous in/out transfers; sel_err unaffected.
REQ-028 sel and src_data SHALL be ignored when in_valid is low.

Reset
REQ-029 reset SHALL force EMPTY, out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1 on the next edge.
REQ-030 reset SHALL take priority over flush and all transfers, including mid-stall in TWO.

Configuration
REQ-031 Macro ALU_SRC_STAGE_CONST_EN defined: sel == NUM_SRC selects CONST_VAL, valid (no sel_err); requires 2**SEL_W > NUM_SRC; sel > NUM_SRC behaves per REQ-026.
REQ-032 Macro undefined: no constant source; every sel >= NUM_SRC behaves per REQ-026.

Verification
REQ-033 Reset then in_valid, sel=1, A=0x0000_1234, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_1234, out_sel=1.
REQ-034 out_ready=0, push PC=0x0040_0000 then A=0x0000_00FF -> in_ready=0 after 2nd; raise out_ready -> 0x0040_0000 then 0x0000_00FF, back-to-back.
REQ-035 Continuous in_valid=1, out_ready=1, 100 alternating sel 0/1 -> 100 outputs in order, one per cycle after first.
REQ-036 NUM_SRC=2, SEL_W=2, sel=3, no macro -> out_data=0, sel_err=1 sticky until reset; with macro, sel=2, CONST_VAL=4 -> out_data=4, sel_err=0.
REQ-037 State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and offered operands absent.
REQ-038 State TWO with out_ready=0, assert reset -> next cycle all outputs at REQ-029 values.
